mem_access_ctrl: RTL

- Parametrised SRAM access sequencer that replaces the fixed-timing MAR/MDR-to-SRAM path.
- The control FSM issues one request through a level handshake. The block then sequences chip-enable, output-enable, write-enable and byte-lane strobes with a configurable number of wait states, captures read data, and returns a one-cycle ack.
- Generalises data width and supports byte-lane writes and slow memories.
- Sits between the processor's MAR/MDR registers and the external SRAM pins.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl_tri_buffer_n.sv | 14 +
 rtl/mem_access_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM access sequencer.
package mem_ctrl_pkg;

  // Access sequence: IDLE -> SETUP -> ACCESS (1+wait states) -> HOLD -> IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Wait-state counter width and the largest wait-state count it can hold
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = (1 << CNT_W) - 1;

  // Legal configuration: byte-granular data bus, wait states fit the counter
  function automatic bit params_ok(input int data_w, input int wait_states);
    return (data_w > 0) && ((data_w % 8) == 0) &&
           (wait_states >= 0) && (wait_states <= MAX_WAIT);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_tri_buffer_n.sv
// Parametrised tri-state driver for the bidirectional SRAM data bus.
module tri_buffer_n #(
  parameter int DATA_W = 16
) (
  input  logic              i_oe,
  input  logic [DATA_W-1:0] i_data,
  inout  wire  [DATA_W-1:0] io_pad,
  output logic [DATA_W-1:0] o_data
);

  assign io_pad = i_oe ? i_data : {DATA_W{1'bz}};
  assign o_data = io_pad;

endmodule

// File: rtl/mem_access_ctrl.sv
// SRAM access sequencer: accepts one level-handshake request, walks the
// SRAM strobes through setup / wait-state access / hold, captures read data
// and returns a one-cycle ack. Every pin-facing output comes from a flop.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                req,
  input  logic                wr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                ack,
  output logic                busy,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  output logic                CE_n,
  output logic                OE_n,
  output logic                WE_n,
  output logic [DATA_W/8-1:0] BE_n
);

  localparam int              BE_W     = DATA_W / 8;
  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_STATES);

  if (!params_ok(DATA_W, WAIT_STATES)) begin : g_bad_params
    $error("mem_access_ctrl: DATA_W must be a multiple of 8 and WAIT_STATES within 0..15");
  end

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_wr;
  logic [DATA_W-1:0]  r_wdata;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_ack;
  logic               r_busy;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [BE_W-1:0]    r_be_n;
  logic               r_dq_oe;

  logic               w_accept;
  logic               w_access_done;
  logic               w_ack;
  logic               w_busy;
  logic               w_ce_n;
  logic               w_oe_n;
  logic               w_we_n;
  logic [BE_W-1:0]    w_be_n;
  logic               w_dq_oe;
  logic [DATA_W-1:0]  w_dq_in;

  assign w_accept      = (r_state == IDLE) && req;
  assign w_access_done = (r_state == ACCESS) && (r_cnt == '0);

  // Next-state logic: fixed single-cycle SETUP and HOLD around a counted ACCESS
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req) w_next_state = SETUP;
      SETUP:   w_next_state = ACCESS;
      ACCESS:  if (r_cnt == '0) w_next_state = HOLD;
      HOLD:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Pin values for the coming state; registered below so pins change on the edge
  // that enters each state. SETUP is only reachable from IDLE, so it uses the
  // live request fields that are being latched on that same edge.
  always_comb begin
    w_ce_n  = 1'b1;
    w_oe_n  = 1'b1;
    w_we_n  = 1'b1;
    w_be_n  = '1;
    w_dq_oe = 1'b0;
    w_busy  = 1'b0;
    w_ack   = 1'b0;
    case (w_next_state)
      SETUP: begin
        w_ce_n = 1'b0;
        w_busy = 1'b1;
        if (wr) begin
          w_be_n  = ~be;
          w_dq_oe = 1'b1;
        end else begin
          w_oe_n = 1'b0;
          w_be_n = '0;
        end
      end
      ACCESS: begin
        w_ce_n = 1'b0;
        w_busy = 1'b1;
        w_be_n = r_be_n;
        if (r_wr) begin
          w_we_n  = 1'b0;
          w_dq_oe = 1'b1;
        end else begin
          w_oe_n = 1'b0;
        end
      end
      HOLD: begin
        // WE_n rises while CE_n, lanes and data stay put: write data hold time
        w_ce_n  = 1'b0;
        w_busy  = 1'b1;
        w_ack   = 1'b1;
        w_be_n  = r_be_n;
        w_dq_oe = r_wr;
      end
      default: ;
    endcase
  end

  // Control state, counter, pin registers and read capture; reset aborts any access
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_addr  <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= '1;
      r_dq_oe <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_be_n  <= w_be_n;
      r_dq_oe <= w_dq_oe;
      if (w_accept) begin
        r_addr <= addr;
      end
      if (r_state == SETUP) begin
        r_cnt <= WAIT_CNT;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access_done && !r_wr) begin
        r_rdata <= w_dq_in;
      end
    end
  end

  // Request attributes held for the whole access; no reset needed on pure data
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_wr    <= wr;
      r_wdata <= wdata;
    end
  end

  tri_buffer_n #(
    .DATA_W (DATA_W)
  ) u_dq_buf (
    .i_oe   (r_dq_oe),
    .i_data (r_wdata),
    .io_pad (SRAM_DQ),
    .o_data (w_dq_in)
  );

  assign rdata     = r_rdata;
  assign ack       = r_ack;
  assign busy      = r_busy;
  assign SRAM_ADDR = r_addr;
  assign CE_n      = r_ce_n;
  assign OE_n      = r_oe_n;
  assign WE_n      = r_we_n;
  assign BE_n      = r_be_n;

endmodule
